// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// framing FSM encoding and the default bit period for 12 MHz / 115200 baud.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 12 MHz HFOSC-derived clock divided down to 115200 baud.
    localparam int CLKS_PER_BIT_12M_115K2 = 12_000_000 / 115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered write and first-word-fall-through read.
// rd_data always shows the head entry; rd_en pops it.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              push;
    logic              pop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign full    = (count == LW'(FIFO_DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: producers push words into a FIFO, the framing
// FSM drains it onto tx with configurable width, parity and stop bits.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | line idle high, waiting for a queued word
//   ST_START  | driving the start bit (0)
//   ST_DATA   | shifting DATA_W payload bits out LSB first
//   ST_PARITY | driving the registered parity bit
//   ST_STOP   | driving STOP_BITS stop bits (1); pops next word at end
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_12M_115K2,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LOAD = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LOAD = BIT_W'(STOP_BITS - 1);

    uart_state_t        state;
    uart_state_t        state_next;
    logic [DATA_W-1:0]  fifo_rd_data;
    logic               fifo_empty;
    logic               pop;
    logic               load;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               baud_tc;
    logic               bit_last;
    logic [DATA_W-1:0]  shreg;
    logic               par_bit;
    logic               par_calc;
    logic               tx_d;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (full),
        .empty   (fifo_empty)
    );

    assign baud_tc  = (baud_cnt == '0);
    assign bit_last = (bit_cnt == '0);
    assign load     = (state_next != state);
    assign par_calc = (PARITY == PAR_ODD) ? ~(^fifo_rd_data) : (^fifo_rd_data);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the FIFO head is popped on every entry to START.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_START;
                    pop        = 1'b1;
                end
            end
            ST_START: begin
                if (baud_tc) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tc && bit_last) begin
                    state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (baud_tc) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tc && bit_last) begin
                    if (!fifo_empty) begin
                        state_next = ST_START;
                        pop        = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: tx_d is the line value for the cycle after this edge,
    // so it looks at the next state and at the shift register as it will be.
    always_comb begin
        tx_d = 1'b1;
        case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = (state == ST_DATA && baud_tc) ? shreg[1] : shreg[0];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
        busy = (state != ST_IDLE);
    end

    // Baud/bit down-counters reload on each state entry; shift register
    // and parity bit are captured when a word is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (load) begin
                baud_cnt <= BAUD_LOAD;
                bit_cnt  <= (state_next == ST_STOP) ? STOP_LOAD : DATA_LOAD;
            end else if (state != ST_IDLE) begin
                if (baud_tc) begin
                    baud_cnt <= BAUD_LOAD;
                    bit_cnt  <= bit_cnt - 1'b1;
                end else begin
                    baud_cnt <= baud_cnt - 1'b1;
                end
            end
            if (pop) begin
                shreg   <= fifo_rd_data;
                par_bit <= par_calc;
            end else if (state == ST_DATA && baud_tc && !load) begin
                shreg <= shreg >> 1;
            end
        end
    end

    // Line driver register; idles high and returns high on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx <= 1'b1;
        end else begin
            tx <= tx_d;
        end
    end

    // One-cycle pulse for every push refused because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: four instances cover 8N1, odd and
// even parity, and a 7-bit / even / two-stop configuration.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr_en;
    logic [7:0] wr_data_b [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] full_w;
    wire  [3:0] ovf_w;
    wire  [4:0] level0;
    wire  [4:0] level1;
    wire  [4:0] level2;
    wire  [2:0] level3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data_b[0]), .full(full_w[0]),
        .level(level0), .overflow(ovf_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data_b[1]), .full(full_w[1]),
        .level(level1), .overflow(ovf_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    uart_tx_buffered #(.CLKS_PER_BIT(4), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data_b[2]), .full(full_w[2]),
        .level(level2), .overflow(ovf_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    uart_tx_buffered #(.CLKS_PER_BIT(3), .DATA_W(7), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data_b[3][6:0]), .full(full_w[3]),
        .level(level3), .overflow(ovf_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    // Serial receiver for instance 0 (4 clocks/bit, 8N1), sampling mid-bit.
    logic [7:0] rx_q [$];
    logic [7:0] rx_sh;
    int         rx_cnt;
    bit         rx_on = 1'b0;

    always @(negedge clk) begin
        if (busy_w[0] !== 1'b1) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx_w[0] === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % 4) == 2 && rx_cnt >= 6 && rx_cnt <= 34) begin
                rx_sh[rx_cnt / 4 - 1] = tx_w[0];
            end
            if (rx_cnt == 38) begin
                rx_q.push_back(rx_sh);
                rx_on = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return tx_w[sel];
    endfunction

    function automatic logic get_busy(input int sel);
        return busy_w[sel];
    endfunction

    // Drive one push for one cycle; returns at the negedge after the write edge.
    task automatic push(input int sel, input logic [7:0] d);
        @(negedge clk);
        wr_en[sel]     = 1'b1;
        wr_data_b[sel] = d;
        @(negedge clk);
        wr_en[sel]     = 1'b0;
    endtask

    // Poll until the start bit appears, bounded.
    task automatic wait_start(input int sel, input string tag);
        int n = 0;
        while (get_tx(sel) !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, get_tx(sel)}, 32'd0);
    endtask

    // Called on the first cycle of a start bit; checks every cycle of the frame.
    task automatic check_frame(input int sel, input int cpb, input logic [15:0] bits,
                               input int nbits, input string tag);
        for (int i = 0; i < nbits * cpb; i++) begin
            chk({tag, "_tx"}, {31'd0, get_tx(sel)}, {31'd0, bits[i / cpb]});
            chk({tag, "_busy"}, {31'd0, get_busy(sel)}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = '0;
        for (int i = 0; i < 4; i++) wr_data_b[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk("rst_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("rst_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("rst_full", {31'd0, full_w[0]}, 32'd0);
        chk("rst_level", {27'd0, level0}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_w[0]}, 32'd0);
        chk("rst_tx3", {31'd0, tx_w[3]}, 32'd1);

        // Single word 0x55, 8N1, 4 clocks/bit
        push(0, 8'h55);
        chk("t1_level_e0", {27'd0, level0}, 32'd1);
        chk("t1_tx_e0", {31'd0, tx_w[0]}, 32'd1);
        chk("t1_busy_e0", {31'd0, busy_w[0]}, 32'd0);
        @(negedge clk);
        chk("t1_level_e1", {27'd0, level0}, 32'd0);
        check_frame(0, 4, 16'({1'b1, 8'h55, 1'b0}), 10, "t1");
        chk("t1_busy_end", {31'd0, busy_w[0]}, 32'd0);
        chk("t1_tx_end", {31'd0, tx_w[0]}, 32'd1);

        // Parity
        push(2, 8'h07);
        wait_start(2, "even07_start");
        check_frame(2, 4, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, "even07");
        chk("even07_idle", {31'd0, busy_w[2]}, 32'd0);
        push(1, 8'h07);
        wait_start(1, "odd07_start");
        check_frame(1, 4, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "odd07");
        push(1, 8'h00);
        wait_start(1, "odd00_start");
        check_frame(1, 4, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, "odd00");
        chk("odd_idle", {31'd0, busy_w[1]}, 32'd0);

        // Overflow: 18 consecutive writes into a 16-deep FIFO
        rx_q.delete();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 1) chk("ov_level_e0", {27'd0, level0}, 32'd1);
            if (i == 2) begin
                chk("ov_level_e1", {27'd0, level0}, 32'd1);
                chk("ov_tx_e1", {31'd0, tx_w[0]}, 32'd0);
            end
            if (i == 16) chk("ov_notfull", {31'd0, full_w[0]}, 32'd0);
            if (i == 17) begin
                chk("ov_full", {31'd0, full_w[0]}, 32'd1);
                chk("ov_level16", {27'd0, level0}, 32'd16);
            end
            chk("ov_noovf", {31'd0, ovf_w[0]}, 32'd0);
            wr_en[0]     = 1'b1;
            wr_data_b[0] = 8'(i);
        end
        @(negedge clk);
        wr_en[0] = 1'b0;
        chk("ov_pulse", {31'd0, ovf_w[0]}, 32'd1);
        chk("ov_level_kept", {27'd0, level0}, 32'd16);
        @(negedge clk);
        chk("ov_pulse_once", {31'd0, ovf_w[0]}, 32'd0);
        begin
            int n = 0;
            while (rx_q.size() < 17 && n < 17 * 40 + 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("ov_nwords", rx_q.size(), 32'd17);
        for (int i = 0; i < rx_q.size(); i++) begin
            chk("ov_word", {24'd0, rx_q[i]}, i);
        end
        repeat (4) @(negedge clk);
        chk("ov_idle", {31'd0, busy_w[0]}, 32'd0);

        // Back-to-back frames
        @(negedge clk);
        wr_en[0] = 1'b1; wr_data_b[0] = 8'hA5;
        @(negedge clk);
        wr_data_b[0] = 8'h3C;
        @(negedge clk);
        wr_en[0] = 1'b0;
        wait_start(0, "b2b_start");
        check_frame(0, 4, 16'({1'b1, 8'hA5, 1'b0}), 10, "b2b_a5");
        check_frame(0, 4, 16'({1'b1, 8'h3C, 1'b0}), 10, "b2b_3c");
        chk("b2b_idle", {31'd0, busy_w[0]}, 32'd0);

        // Reset in the middle of data bit 3 with two words queued
        @(negedge clk);
        wr_en[0] = 1'b1; wr_data_b[0] = 8'h11;
        @(negedge clk);
        wr_data_b[0] = 8'h22;
        @(negedge clk);
        wr_data_b[0] = 8'h33;
        @(negedge clk);
        wr_en[0] = 1'b0;
        wait_start(0, "mr_start");
        repeat (17) @(negedge clk);
        chk("mr_level_before", {27'd0, level0}, 32'd2);
        chk("mr_busy_before", {31'd0, busy_w[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("mr_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("mr_level", {27'd0, level0}, 32'd0);
        push(0, 8'h81);
        wait_start(0, "mr81_start");
        check_frame(0, 4, 16'({1'b1, 8'h81, 1'b0}), 10, "mr81");
        chk("mr81_idle", {31'd0, busy_w[0]}, 32'd0);

        // 7 data bits, even parity, two stop bits, 3 clocks/bit
        push(3, 8'h7F);
        wait_start(3, "w7_start");
        check_frame(3, 3, 16'({2'b11, 1'b1, 7'h7F, 1'b0}), 11, "w7");
        chk("w7_idle", {31'd0, busy_w[3]}, 32'd0);
        chk("w7_tx_idle", {31'd0, tx_w[3]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered, parametrised UART transmitter for the iCE40 UltraPlus designs. It replaces the bare `uart_tx` start/ready pairing: producers such as ADC capture and FFT output push words into an internal FIFO without waiting on the line. A framing state machine drains the FIFO onto `tx` with configurable word width, parity and stop bits. It runs on the 12 MHz HFOSC-derived clock domain.

## Interface
- `CLKS_PER_BIT`, default 104: clocks per UART bit (12 MHz / 115200); legal range ≥ 2.
- `DATA_W`, default 8: payload bits per frame; legal range 5–9.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset is synchronous and active-high. There is one clock; name it `clk`, name the reset `rst`.
- `wr_en` in, 1: push request.
- `wr_data` in, `DATA_W`: word to transmit.
- `full` out, 1: FIFO holds `FIFO_DEPTH` words.
- `level` out, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow` out, 1: one-cycle pulse when a push is dropped.
- `tx` out, 1: serial line, idle high.
- `busy` out, 1: a frame is in progress (any state other than IDLE).

## Operation
- Push: when `wr_en` is high and `full` is low, the word is written at that edge. When `wr_en` is high and `full` is high, the word is dropped and `overflow` is high for the next cycle. A push is dropped while full even if a pop happens in the same cycle.
- Simultaneous push and pop when not full leaves `level` unchanged.
- Frame: start bit (0), then `DATA_W` data bits LSB first, then an optional parity bit, then `STOP_BITS` stop bits (1).
  - Odd parity: the total count of ones across data and parity is odd.
  - Even parity: the total count of ones is even.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is not empty. The head word is popped into the shift register at the same edge.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY (or STOP when `PARITY`=0) after `DATA_W` bit periods.
  - PARITY → STOP after one bit period.
  - At the end of the last stop bit: if the FIFO is not empty, go to START and pop at that edge (no idle gap). Otherwise go to IDLE.
- A bit counter and a baud counter (width `$clog2(CLKS_PER_BIT)`) reload on every state entry.
- Parity is computed from the word at load time and registered.
- Reset values: `tx`=1, `busy`=0, `full`=0, `level`=0, `overflow`=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame truncates the frame. `tx` is 1 from the cycle after `rst` is sampled, and FIFO contents are discarded.
- `tx` is driven from a register, never combinationally.

## Timing
- `wr_en` at edge E0 into an empty FIFO with the FSM in IDLE: `level`=1 after E0. The FSM pops at E1, `tx`=0 and `busy`=1 after E1, and `level`=0 after E1.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Frame length is (1 + `DATA_W` + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `busy` falls on the edge that ends the last stop bit, and only if the FIFO is empty.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `full` and `level` update on the edge after the push or pop.
- `overflow` is high for exactly one cycle per dropped word.

## Structure
- Shared package `uart_pkg`:
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - FSM state encoding;
  - a `CLKS_PER_BIT` helper constant for 12 MHz / 115200.
- One sub-module, `sync_fifo`, parametrised on `DATA_W` and `FIFO_DEPTH`:
  - registered write;
  - first-word-fall-through read;
  - `level`, `full` and `empty` outputs;
  - synchronous reset.
- Target size is about 150–250 lines of RTL in total.

## Test plan
- Single word, `CLKS_PER_BIT`=4, `DATA_W`=8, `PARITY`=0, `STOP_BITS`=1: write 0x55 at E0.
  - `tx` falls after E1.
  - `tx` then reads 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop), each for 4 cycles.
  - `busy` is high for exactly 40 cycles.
- Parity: send 0x07 with `PARITY`=2; the parity bit is 1. Send 0x07 with `PARITY`=1; the parity bit is 0. Send 0x00 with `PARITY`=1; the parity bit is 1.
- Overflow, `FIFO_DEPTH`=16: write words 0..17 on consecutive cycles.
  - Word 0 is popped at E1.
  - `full` rises after the 17th write; the 18th write is dropped and `overflow` pulses once.
  - The line carries words 0..16 in order.
- Back-to-back: write 0xA5 and 0x3C on consecutive cycles. The start bit of 0x3C begins on the cycle right after the stop bit of 0xA5. `busy` never drops between the two frames.
- Reset mid-frame: assert `rst` for one cycle during data bit 3 with 2 words still queued.
  - On the next cycle: `tx`=1, `busy`=0, `level`=0.
  - A later write of 0x81 transmits correctly.
- `DATA_W`=7, `STOP_BITS`=2, `PARITY`=2, `CLKS_PER_BIT`=3: send 0x7F.
  - Frame: 0 (start), seven 1s, parity 1, then 1,1 (two stop bits).
  - Total length is 33 cycles.
